// File: rtl/bit_clmul_iter_pkg.sv
// Shared types and helpers for the iterative carry-less multiplier (Zbc clmul/clmulh/clmulr).
package bit_clmul_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  // Which slice of the 2*XLEN product becomes the result.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LO,
    SEL_HI,
    SEL_REV
  } sel_t;

  localparam int OP_CLMUL  = 0;
  localparam int OP_CLMULH = 1;
  localparam int OP_CLMULR = 2;

  function automatic sel_t decode_op(input logic [2:0] op);
    if (op[OP_CLMUL]) return SEL_LO;
    if (op[OP_CLMULH]) return SEL_HI;
    if (op[OP_CLMULR]) return SEL_REV;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/bit_clmul_iter_clmul_partial.sv
// One iteration of the carry-less multiply: folds STEP shifted copies of the
// multiplicand into the accumulator, selected by the low multiplier bits.
module clmul_partial
  import bit_clmul_iter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [2*XLEN-1:0] a_i,
  input  logic [STEP-1:0]   b_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int j = 0; j < STEP; j++) begin
      if (b_i[j]) acc_o = acc_o ^ (a_i << j);
    end
  end

endmodule

// File: rtl/bit_clmul_iter.sv
// Iterative carry-less multiplier retiring STEP multiplier bits per cycle, with
// early exit once the remaining multiplier bits are zero and a synchronous abort.
module bit_clmul_iter
  import bit_clmul_iter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            clear,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            busy
);

  localparam int NITER = XLEN / STEP;
  localparam int CW    = $clog2(NITER);

  typedef struct packed {
    state_t              state;
    sel_t                sel;
    logic [2*XLEN-1:0]   a;
    logic [XLEN-1:0]     b;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       cnt;
    logic [XLEN-1:0]     result;
    logic                ready;
  } reg_t;

  localparam reg_t REG_INIT = '{
    state:  ST_IDLE,
    sel:    SEL_NONE,
    a:      '0,
    b:      '0,
    acc:    '0,
    cnt:    '0,
    result: '0,
    ready:  1'b0
  };

  function automatic logic [XLEN-1:0] pick_result(input sel_t s, input logic [2*XLEN-1:0] acc);
    case (s)
      SEL_LO:  return acc[XLEN-1:0];
      SEL_HI:  return acc[2*XLEN-1:XLEN];
      SEL_REV: return acc[2*XLEN-2:XLEN-1];
      default: return '0;
    endcase
  endfunction

  reg_t              r_q;
  reg_t              r_d;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   b_next;
  logic              start;
  logic              last_iter;

  clmul_partial #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_partial (
    .a_i   (r_q.a),
    .b_i   (r_q.b[STEP-1:0]),
    .acc_i (r_q.acc),
    .acc_o (acc_step)
  );

  assign start     = enable && (op != 3'b000) && ((r_q.state == ST_IDLE) || (r_q.state == ST_DONE));
  assign b_next    = r_q.b >> STEP;
  assign last_iter = (r_q.cnt == CW'(NITER - 1)) || (b_next == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= REG_INIT;
    else     r_q <= r_d;
  end

  always_comb begin
    r_d       = r_q;
    r_d.ready = 1'b0;
    case (r_q.state)
      ST_BUSY: begin
        r_d.acc = acc_step;
        r_d.a   = r_q.a << STEP;
        r_d.b   = b_next;
        r_d.cnt = r_q.cnt + CW'(1);
        // The final partial product is folded in on the same edge the result is captured.
        if (last_iter) begin
          r_d.state  = ST_DONE;
          r_d.ready  = 1'b1;
          r_d.result = pick_result(r_q.sel, acc_step);
        end
      end
      default: begin
        if (start) begin
          r_d.sel    = decode_op(op);
          r_d.a      = {{XLEN{1'b0}}, rdata1};
          r_d.b      = rdata2;
          r_d.acc    = '0;
          r_d.cnt    = '0;
          r_d.result = '0;
          if (rdata2 == '0) begin
            r_d.state = ST_DONE;
            r_d.ready = 1'b1;
          end else begin
            r_d.state = ST_BUSY;
          end
        end else begin
          r_d.state = ST_IDLE;
        end
      end
    endcase
    // Flush wins over a new start and over completion on the same edge.
    if (clear) begin
      r_d.state  = ST_IDLE;
      r_d.ready  = 1'b0;
      r_d.result = '0;
      r_d.cnt    = '0;
    end
  end

  always_comb begin
    result = r_q.result;
    ready  = r_q.ready;
    busy   = (r_q.state == ST_BUSY);
  end

endmodule

// File: doc/bit_clmul_iter.md
Name: bit_clmul_iter

Overview:
- Parametrised iterative carry-less multiplier for the Zbc bit-manipulation unit (clmul, clmulh, clmulr).
- Generalises the 32-bit, 1-bit-per-cycle unit: configurable XLEN, configurable bits retired per cycle, early termination when the remaining multiplier bits are zero, and a synchronous abort.
- Sits beside the ALU in the execute stage; execute stalls until ready.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- STEP, 1, multiplier bits retired per cycle (1, 2, 4 or 8); XLEN mod STEP must be 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  start request, sampled only in IDLE or DONE
- op  in  3  {clmulr, clmulh, clmul}; priority clmul > clmulh > clmulr; zero means no operation
- rdata1  in  XLEN  multiplicand
- rdata2  in  XLEN  multiplier
- clear  in  1  synchronous abort (pipeline flush)
- result  out  XLEN  registered result; held from DONE until the next accepted start or clear
- ready  out  1  registered; high for exactly one cycle (DONE)
- busy  out  1  high in BUSY

Behaviour:
- Reset (async, rst=1): state=IDLE; acc=0, a=0, b=0, cnt=0, result=0, ready=0, busy=0.
- States: IDLE, BUSY, DONE.
- Start: enable=1 and op!=0 in IDLE or DONE.
  - Loads a = zero-extended rdata1 (2*XLEN bits), b = rdata2, acc = 0, cnt = 0, and the latched op.
  - Next state is BUSY, or DONE if rdata2 == 0; in that case result = 0 and ready is high in the cycle after the start edge.
- BUSY, each edge:
  - acc ^= XOR over j < STEP of (b[j] ? a << j : 0).
  - a <<= STEP; b >>= STEP; cnt++.
  - Go to DONE if cnt == XLEN/STEP-1 or (b >> STEP) == 0; otherwise stay in BUSY.
  - On that same edge, result is loaded from the final acc (including the current step):
    - clmul: acc[XLEN-1:0]
    - clmulh: acc[2XLEN-1:XLEN]
    - clmulr: acc[2XLEN-2:XLEN-1]
- DONE: ready=1 for one cycle.
  - Next state is BUSY on a new start (back-to-back), else IDLE.
- Latency from the start edge to ready high is 1 + ceil((msb_index(rdata2)+1)/STEP) cycles, with a maximum of XLEN/STEP + 1.
  - Example: XLEN=32, STEP=1, rdata2 bit31 set: ready is high after the 33rd edge.
- enable while BUSY: ignored; no queueing. The requester must hold its request until ready.
- Inputs rdata1, rdata2 and op are only sampled on the start edge; later changes have no effect.
- clear=1 at any edge:
  - state=IDLE, ready=0, result=0, cnt=0.
  - Has priority over enable and over BUSY→DONE completion on the same edge.
- Reset mid-operation: immediate return to the reset values; no partial result visible.
- acc is 2*XLEN bits wide, with no overflow possible. The shift of a is bounded: bits above 2*XLEN-1 are discarded.

Decomposition:
- Shared wires package gets:
  - bit_clmul_iter_in_type {enable, clear, op, rdata1, rdata2}
  - bit_clmul_iter_out_type {result, ready, busy}
  - bit_clmul_iter_reg_type {state, op, a, b, acc, cnt, result, ready}
  - state enum and init_bit_clmul_iter_reg
- Widths derive from XLEN, so the package types use the maximum XLEN=64 with masking; alternatively the types live in a parametrised interface-free local typedef. The team default is package types at 64 bits.
- Sub-module clmul_partial (combinational):
  - Inputs a (2*XLEN), b slice (STEP), acc.
  - Output acc ^ partial products.
  - Unit-tested separately.
- Single two-process (comb + ff) style for the FSM.

Test Plan:
- XLEN=32, STEP=1, clmul rdata1=0x3, rdata2=0x3 → result=0x00000005; ready high exactly 1 cycle, 3 cycles after the start edge (two BUSY iterations, early exit).
- XLEN=32, clmulh and clmulr with rdata1=rdata2=0x80000000 → clmulh=0x40000000, clmulr=0x80000000; latency 33 cycles at STEP=1 and 9 cycles at STEP=4.
- XLEN=32, STEP=4, clmul and clmulh with rdata1=rdata2=0xFFFFFFFF → both 0x55555555; ready on cycle 9.
- rdata2=0x0, any op → result=0, ready one cycle after the start edge; busy never asserted.
- clear asserted on the 5th BUSY cycle, with enable high on the same edge → IDLE, ready never pulses, result=0. A new start afterwards with 0x3×0x3 clmul → 0x5.
- Back-to-back: a start in the DONE cycle with new operands → the first result is valid during DONE, the second ready follows at the expected latency. Async rst pulse mid-BUSY → all outputs 0 immediately, without waiting for a clock edge.
